main_fsm: RTL and testbench

MAIN_FSM -- requirements
Module: main_fsm

---
 rtl/main_fsm_pkg.sv | 34 +++
 rtl/main_fsm.sv | 147 ++++++++++++++
 tb/tb_main_fsm.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg: shared definitions for the multicycle control FSM.
//   state_e     - controller state encoding (also exported on main_fsm.state)
//   SRCB_*      - alu_src_b select codes
//   RES_*       - result_src select codes
//   OP_*        - instruction class codes on main_fsm.op
package main_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_e;

    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    localparam logic [1:0] OP_DP       = 2'b00;
    localparam logic [1:0] OP_MEM      = 2'b01;
    localparam logic [1:0] OP_BRANCH   = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// main_fsm: multicycle processor main controller (Moore FSM with memory
// handshake gating on the fetch / store strobes).
// Ports:
//   clk          - clock, all state changes on rising edge
//   reset        - synchronous active-low reset
//   op[1:0]      - instruction class
//   funct[5:0]   - bit5 immediate, bit0 load/store select
//   mem_ready    - memory access completes this cycle
//   ir_write, next_pc, reg_w, mem_w, branch - enable strobes
//   adr_src, alu_src_a, alu_op, alu_src_b[1:0], result_src[1:0] - datapath selects
//   instr_done   - pulse on last cycle of each instruction
//   illegal      - high in UNKNOWN
//   state[3:0]   - current state register, for debug
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       next_pc,
    output logic       reg_w,
    output logic       mem_w,
    output logic       branch,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic       alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;
    state_e out_state;

    // funct[4:1] carry no meaning for this controller
    logic unused_funct;
    assign unused_funct = ^funct[4:1];

    always_ff @(posedge clk) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_DP:     state_d = funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:    state_d = MEMADR;
                    OP_BRANCH: state_d = BRANCH;
                    default:   state_d = UNKNOWN;
                endcase
            end
            MEMADR:   state_d = funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:    state_d = FETCH;
            MEMWR:    state_d = mem_ready ? FETCH : MEMWR;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            UNKNOWN:  state_d = UNKNOWN;
            default:  state_d = FETCH;
        endcase
    end

    // While reset is low the outputs already show FETCH behaviour, so no
    // strobe belonging to the interrupted state can fire in that cycle.
    assign out_state = reset ? state_q : FETCH;

    always_comb begin
        ir_write   = 1'b0;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_op     = 1'b0;
        alu_src_b  = SRCB_RD2;
        result_src = RES_ALUOUT;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (out_state)
            FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
                ir_write   = mem_ready;
                next_pc    = mem_ready;
            end
            DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURES;
            end
            MEMADR: begin
                alu_src_b  = SRCB_EXTIMM;
            end
            MEMRD: begin
                adr_src    = 1'b1;
            end
            MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                adr_src    = 1'b1;
                mem_w      = mem_ready;
                instr_done = mem_ready;
            end
            EXECUTER: begin
                alu_op     = 1'b1;
            end
            EXECUTEI: begin
                alu_src_b  = SRCB_EXTIMM;
                alu_op     = 1'b1;
            end
            ALUWB: begin
                reg_w      = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_b  = SRCB_EXTIMM;
                result_src = RES_ALURES;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            UNKNOWN: begin
                illegal    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: self-checking bench for main_fsm. Each instruction is expanded
// into its expected per-cycle state trace (fetch waits, class-specific phases,
// memory waits); every cycle's outputs are checked against the output table,
// and per-instruction strobe pulse counts are checked afterwards.
module tb_main_fsm;
    import main_fsm_pkg::*;

    logic       clk;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       mem_ready;
    logic       ir_write, next_pc, reg_w, mem_w, branch;
    logic       adr_src, alu_src_a, alu_op;
    logic [1:0] alu_src_b, result_src;
    logic       instr_done, illegal;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;
    int irw_cnt, memw_cnt, done_cnt, regw_cnt;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
        .ir_write(ir_write), .next_pc(next_pc), .reg_w(reg_w), .mem_w(mem_w),
        .branch(branch), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .result_src(result_src), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    logic [14:0] obs;
    assign obs = {ir_write, next_pc, reg_w, mem_w, branch, adr_src, alu_src_a,
                  alu_op, alu_src_b, result_src, instr_done, illegal};

    // Output table: what each state must drive, given mem_ready.
    function automatic logic [14:0] exp_out(input state_e s, input logic mr);
        logic irw, npc, rw, mw, br, adr, asa, aop, done, ill;
        logic [1:0] asb, rs;
        irw = 0; npc = 0; rw = 0; mw = 0; br = 0; adr = 0; asa = 0; aop = 0;
        done = 0; ill = 0; asb = 2'b00; rs = 2'b00;
        case (s)
            FETCH:    begin irw = mr; npc = mr; asa = 1; asb = 2'b10; rs = 2'b10; end
            DECODE:   begin asa = 1; asb = 2'b10; rs = 2'b10; end
            MEMADR:   begin asb = 2'b01; end
            MEMRD:    begin adr = 1; end
            MEMWB:    begin rs = 2'b01; rw = 1; done = 1; end
            MEMWR:    begin adr = 1; mw = mr; done = mr; end
            EXECUTER: begin aop = 1; end
            EXECUTEI: begin aop = 1; asb = 2'b01; end
            ALUWB:    begin rw = 1; done = 1; end
            BRANCH:   begin asb = 2'b01; rs = 2'b10; br = 1; done = 1; end
            UNKNOWN:  begin ill = 1; end
            default: ;
        endcase
        return {irw, npc, rw, mw, br, adr, asa, aop, asb, rs, done, ill};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs after the edge, then check state register
    // (st) and outputs (expected as state ost would drive them).
    task automatic step(input state_e st, input state_e ost, input logic mr,
                        input logic rst, input string tag);
        @(posedge clk);
        #1;
        reset = rst;
        mem_ready = mr;
        #1;
        tests++;
        assert (state === 4'(st)) else begin
            fails++;
            $error("FAIL %s state: got %0d want %0d", tag, state, st);
        end
        tests++;
        assert (obs === exp_out(ost, mr)) else begin
            fails++;
            $error("FAIL %s outputs: got %b want %b", tag, obs, exp_out(ost, mr));
        end
        irw_cnt  += int'(ir_write);
        memw_cnt += int'(mem_w);
        done_cnt += int'(instr_done);
        regw_cnt += int'(reg_w);
    endtask

    task automatic check_cnt(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic run_instr(input logic [1:0] iop, input logic [5:0] ifn,
                             input int fwait, input int mwait, input string tag);
        state_e ex;
        op = iop;
        funct = ifn;
        irw_cnt = 0; memw_cnt = 0; done_cnt = 0; regw_cnt = 0;
        for (int i = 0; i < fwait; i++) step(FETCH, FETCH, 1'b0, 1'b1, tag);
        step(FETCH, FETCH, 1'b1, 1'b1, tag);
        step(DECODE, DECODE, rnd_bit(), 1'b1, tag);
        case (iop)
            2'b00: begin
                ex = ifn[5] ? EXECUTEI : EXECUTER;
                step(ex, ex, rnd_bit(), 1'b1, tag);
                step(ALUWB, ALUWB, rnd_bit(), 1'b1, tag);
            end
            2'b01: begin
                step(MEMADR, MEMADR, rnd_bit(), 1'b1, tag);
                ex = ifn[0] ? MEMRD : MEMWR;
                for (int i = 0; i < mwait; i++) step(ex, ex, 1'b0, 1'b1, tag);
                step(ex, ex, 1'b1, 1'b1, tag);
                if (ifn[0]) step(MEMWB, MEMWB, rnd_bit(), 1'b1, tag);
            end
            2'b10: step(BRANCH, BRANCH, rnd_bit(), 1'b1, tag);
            default: begin
                for (int i = 0; i < 12; i++) step(UNKNOWN, UNKNOWN, rnd_bit(), 1'b1, tag);
            end
        endcase
        check_cnt({tag, " ir_write pulses"}, irw_cnt, 1);
        check_cnt({tag, " mem_w pulses"}, memw_cnt, (iop == 2'b01 && !ifn[0]) ? 1 : 0);
        check_cnt({tag, " instr_done pulses"}, done_cnt, (iop == 2'b11) ? 0 : 1);
        check_cnt({tag, " reg_w pulses"}, regw_cnt,
                  (iop == 2'b00 || (iop == 2'b01 && ifn[0])) ? 1 : 0);
        // Only reset leaves UNKNOWN; outputs revert to FETCH in the reset cycle.
        if (iop == 2'b11) step(UNKNOWN, FETCH, rnd_bit(), 1'b0, {tag, " reset"});
    endtask

    initial begin
        reset = 1'b0;
        mem_ready = 1'b1;
        op = 2'b00;
        funct = '0;

        // Reset held 3 cycles with mem_ready high; release checked by next fetch.
        for (int i = 0; i < 3; i++) step(FETCH, FETCH, 1'b1, 1'b0, "reset");

        run_instr(2'b00, 6'b100000, 0, 0, "dp_imm");
        run_instr(2'b00, 6'b000000, 0, 0, "dp_reg");
        run_instr(2'b01, 6'b000001, 0, 2, "load_wait2");
        run_instr(2'b01, 6'b000000, 0, 2, "store_wait2");
        run_instr(2'b10, 6'b000000, 2, 0, "branch_fwait");
        run_instr(2'b11, 6'b000000, 0, 0, "undef");

        // Reset during a stalled store: no mem_w, FETCH on the next edge.
        op = 2'b01;
        funct = 6'b000000;
        memw_cnt = 0;
        step(FETCH, FETCH, 1'b1, 1'b1, "rst_store");
        step(DECODE, DECODE, 1'b0, 1'b1, "rst_store");
        step(MEMADR, MEMADR, 1'b0, 1'b1, "rst_store");
        step(MEMWR, MEMWR, 1'b0, 1'b1, "rst_store");
        step(MEMWR, FETCH, 1'b0, 1'b0, "rst_store_in_reset");
        check_cnt("rst_store mem_w pulses", memw_cnt, 0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0] rop;
            logic [5:0] rfn;
            rop = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rfn = 6'($urandom);
            run_instr(rop, rfn, $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
